// File: rtl/start_sequencer.sv
// start_sequencer: queues job requests and issues one start pulse per job to a downstream busy counter.
module start_sequencer #(
  parameter int MAX_PENDING = 4,
  parameter int PEND_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_request,
  input  logic              i_busy,
  output logic              o_start,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_done,
  output logic              o_overflow
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT_ACK = 2'd2, WAIT_DONE = 2'd3;
  localparam logic [PEND_W-1:0] FULL = PEND_W'(MAX_PENDING);
  logic [1:0] state, state_nx;
  logic full, inc, dec, drop;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? ((o_pending != '0 && !i_busy) ? START : IDLE) :
               (state == START) ? WAIT_ACK :
               (i_busy ? WAIT_DONE : IDLE);
  end
  assign dec = state == START;
  assign full = o_pending == FULL;
  // A request at the limit still fits when this cycle issues a start.
  assign inc = i_request && (!full || dec);
  assign drop = i_request && full && !dec;
  assign o_start = state == START;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      o_pending <= '0;
      o_done <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      o_pending <= o_pending + PEND_W'(inc) - PEND_W'(dec);
      o_done <= (state == WAIT_ACK || state == WAIT_DONE) && !i_busy;
      if (drop) o_overflow <= 1'b1;
    end
  end
`ifdef FORMAL
  a_start_moore: assert property (@(posedge i_clk) o_start == (state == START));
  a_no_start_busy: assert property (@(posedge i_clk) disable iff (!i_reset_n) !(o_start && i_busy));
  a_bound: assert property (@(posedge i_clk) o_pending <= FULL);
  a_inc: assert property (@(posedge i_clk) i_reset_n && i_request && !dec && !full |=> o_pending == $past(o_pending) + 1'b1);
  a_dec: assert property (@(posedge i_clk) i_reset_n && dec && !i_request |=> o_pending == $past(o_pending) - 1'b1);
  a_both: assert property (@(posedge i_clk) i_reset_n && dec && i_request |=> o_pending == $past(o_pending));
  a_drop: assert property (@(posedge i_clk) i_reset_n && drop |=> o_pending == FULL && o_overflow);
  a_full_start: assert property (@(posedge i_clk) i_reset_n && !o_overflow && i_request && full && dec |=> !o_overflow);
  a_sticky: assert property (@(posedge i_clk) i_reset_n && o_overflow |=> o_overflow);
`endif
endmodule

// File: tb/tb_start_sequencer.sv
// tb_start_sequencer: directed scenario tests with a behavioural busy-counter model downstream.
module tb_start_sequencer;
  logic clk = 1'b0;
  logic reset_n, request, busy, start, done, overflow;
  logic [3:0] pending;
  logic [5:0] bcnt;
  logic cnt_clr, force_busy;
  int max_amount;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  start_sequencer #(.MAX_PENDING(4), .PEND_W(4)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_request(request), .i_busy(busy),
    .o_start(start), .o_pending(pending), .o_done(done), .o_overflow(overflow)
  );
  // Downstream busy counter: start in cycle N -> busy in N+1 .. N+max_amount-1.
  always @(posedge clk)
    if (cnt_clr) bcnt <= '0;
    else if (start && bcnt == 0) bcnt <= 6'(max_amount - 1);
    else if (bcnt != 0) bcnt <= bcnt - 1'b1;
  assign busy = (bcnt != 0) || force_busy;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic clr);
    reset_n = 1'b0; request = 1'b0; force_busy = 1'b0; cnt_clr = clr;
    repeat (2) cyc();
    reset_n = 1'b1; cnt_clr = 1'b0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0; request = 1'b1; cnt_clr = 1'b1; force_busy = 1'b0;
    cyc();
    @(negedge clk);
    checks++; if (pending !== 4'd0) $display("FAIL reset_pending got %0d want 0", pending); else passes++;
    checks++; if (start !== 1'b0) $display("FAIL reset_start got %b want 0", start); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passes++;
    cyc();
    reset_n = 1'b1; request = 1'b0; cnt_clr = 1'b0;
  endtask
  task automatic test_single();
    logic [3:0] ep;
    max_amount = 22;
    do_reset(1'b1);
    for (int c = 0; c <= 27; c++) begin
      request = (c == 0);
      @(negedge clk);
      ep = (c == 1 || c == 2) ? 4'd1 : 4'd0;
      checks++; if (pending !== ep) $display("FAIL single_pending c%0d got %0d want %0d", c, pending, ep); else passes++;
      checks++; if (start !== (c == 2)) $display("FAIL single_start c%0d got %b want %b", c, start, c == 2); else passes++;
      checks++; if (busy !== (c >= 3 && c <= 23)) $display("FAIL single_busy c%0d got %b", c, busy); else passes++;
      checks++; if (done !== (c == 25)) $display("FAIL single_done c%0d got %b want %b", c, done, c == 25); else passes++;
      cyc();
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] ep;
    max_amount = 22;
    do_reset(1'b1);
    for (int c = 0; c <= 50; c++) begin
      request = (c <= 1);
      @(negedge clk);
      ep = (c == 1) ? 4'd1 : (c == 2) ? 4'd2 : (c >= 3 && c <= 26) ? 4'd1 : 4'd0;
      checks++; if (pending !== ep) $display("FAIL b2b_pending c%0d got %0d want %0d", c, pending, ep); else passes++;
      checks++; if (start !== (c == 2 || c == 26)) $display("FAIL b2b_start c%0d got %b", c, start); else passes++;
      checks++; if (done !== (c == 25 || c == 49)) $display("FAIL b2b_done c%0d got %b", c, done); else passes++;
      checks++; if (start && busy) $display("FAIL b2b_start_while_busy c%0d got 1 want 0", c); else passes++;
      cyc();
    end
  endtask
  task automatic test_overflow();
    logic [3:0] ep;
    max_amount = 22;
    do_reset(1'b1);
    for (int c = 0; c <= 10; c++) begin
      request = (c <= 5);
      @(negedge clk);
      ep = (c == 0) ? 4'd0 : (c == 1) ? 4'd1 : (c <= 3) ? 4'd2 : (c == 4) ? 4'd3 : 4'd4;
      checks++; if (pending !== ep) $display("FAIL ovf_pending c%0d got %0d want %0d", c, pending, ep); else passes++;
      checks++; if (overflow !== (c >= 6)) $display("FAIL ovf_flag c%0d got %b want %b", c, overflow, c >= 6); else passes++;
      cyc();
    end
  endtask
  task automatic test_full_start();
    max_amount = 22;
    do_reset(1'b1);
    for (int c = 0; c <= 7; c++) begin
      force_busy = (c <= 3);
      request = (c <= 3 || c == 5);
      @(negedge clk);
      checks++; if (pending !== ((c == 0) ? 4'd0 : (c <= 4) ? 4'(c) : 4'd4))
        $display("FAIL full_pending c%0d got %0d", c, pending); else passes++;
      checks++; if (start !== (c == 5)) $display("FAIL full_start c%0d got %b want %b", c, start, c == 5); else passes++;
      checks++; if (overflow !== 1'b0) $display("FAIL full_overflow c%0d got %b want 0", c, overflow); else passes++;
      cyc();
    end
    force_busy = 1'b0; request = 1'b0;
  endtask
  task automatic test_zero_len();
    max_amount = 1;
    do_reset(1'b1);
    for (int c = 0; c <= 6; c++) begin
      request = (c == 0);
      @(negedge clk);
      checks++; if (start !== (c == 2)) $display("FAIL zl_start c%0d got %b want %b", c, start, c == 2); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL zl_busy c%0d got %b want 0", c, busy); else passes++;
      checks++; if (done !== (c == 4)) $display("FAIL zl_done c%0d got %b want %b", c, done, c == 4); else passes++;
      cyc();
    end
  endtask
  task automatic test_reset_mid_job();
    max_amount = 22;
    do_reset(1'b1);
    for (int c = 0; c <= 28; c++) begin
      request = (c == 0 || c == 12);
      reset_n = (c != 10);
      @(negedge clk);
      if (c >= 11) begin
        checks++; if (pending !== ((c >= 13 && c <= 25) ? 4'd1 : 4'd0))
          $display("FAIL mid_pending c%0d got %0d", c, pending); else passes++;
        checks++; if (start !== (c == 25)) $display("FAIL mid_start c%0d got %b want %b", c, start, c == 25); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL mid_done c%0d got %b want 0", c, done); else passes++;
      end
      cyc();
    end
    reset_n = 1'b1;
  endtask
  task automatic test_random();
    int reqs = 0, starts = 0, drops = 0;
    max_amount = 5;
    do_reset(1'b1);
    for (int c = 0; c < 400; c++) begin
      request = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (start && busy) $display("FAIL rnd_start_while_busy c%0d got 1 want 0", c); else passes++;
      checks++; if (starts + drops + int'(pending) != reqs)
        $display("FAIL rnd_conservation c%0d got %0d want %0d", c, starts + drops + int'(pending), reqs); else passes++;
      reqs += int'(request);
      starts += int'(start);
      drops += int'(request && pending == 4'd4 && !start);
      cyc();
    end
    request = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0; request = 1'b0; cnt_clr = 1'b1; force_busy = 1'b0; max_amount = 22;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset();
    test_full_start();
    test_zero_len();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter MAX_PENDING, default 4, meaning maximum number of queued job requests (1..15).
REQ-002 Parameter PEND_W, default 4, meaning width of the pending count; it SHALL hold MAX_PENDING.
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 i_reset_n  input  1  reset, synchronous and active-low.
REQ-005 i_request  input  1  one job request per cycle it is high.
REQ-006 i_busy  input  1  busy flag from the downstream busy counter (its o_busy).
REQ-007 o_start  output  1  start pulse to the downstream counter (its i_start_signal).
REQ-008 o_pending  output  PEND_W  number of queued, not-yet-issued requests.
REQ-009 o_done  output  1  one-cycle pulse when an issued job has completed.
REQ-010 o_overflow  output  1  sticky flag: a request was dropped.

Function
REQ-011 The FSM SHALL have four states: IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-012 IDLE -> START when o_pending != 0 and i_busy == 0; otherwise stay in IDLE.
REQ-013 START SHALL last exactly one cycle, then go to WAIT_ACK.
REQ-014 o_start SHALL be 1 exactly while state == START (Moore, registered state, no combinational path from any input).
REQ-015 WAIT_ACK SHALL last one cycle: i_busy == 1 -> WAIT_DONE; i_busy == 0 -> IDLE (zero-length job).
REQ-016 WAIT_DONE -> IDLE on the first cycle with i_busy == 0.
REQ-017 o_done SHALL be a registered pulse, high for exactly the first cycle of IDLE following WAIT_ACK or WAIT_DONE.
REQ-018 Pending count: +1 on i_request, -1 in the START cycle; both in the same cycle -> unchanged.
REQ-019 A request arriving when count == MAX_PENDING with no same-cycle decrement SHALL be dropped; count stays at MAX_PENDING; o_overflow is set from the next cycle.
REQ-020 A request at count == MAX_PENDING in a START cycle SHALL be accepted; the count stays unchanged; o_overflow is not set.
REQ-021 o_overflow SHALL stay high until reset.
REQ-022 o_start SHALL never be high in a cycle where i_busy is high.
REQ-023 If i_busy is high in IDLE, for example from a busy counter still running after reset, the block SHALL hold in IDLE with pending requests retained.
REQ-024 Latency: with the block IDLE, empty and i_busy low, a request in cycle N SHALL give o_pending = 1 in N+1 and o_start in N+2.

Reset
REQ-025 With i_reset_n low at a rising edge: state = IDLE; o_pending = 0; o_start = o_done = o_overflow = 0 from the next cycle.
REQ-026 Reset SHALL take priority over every other event, including a same-cycle i_request.
REQ-027 Reset mid-job SHALL drop all queued requests; the in-flight downstream job is not tracked.

Structure
REQ-028 No shared package; state encodings SHALL be localparams inside the module; MAX_PENDING and PEND_W SHALL be parameters only.
REQ-029 No sub-module; the downstream counter is instantiated only in the test or integration wrapper.
REQ-030 The module SHALL carry an `ifdef FORMAL` section asserting REQ-014, REQ-018 to REQ-022 and o_pending <= MAX_PENDING.

Verification (MAX_PENDING=4; downstream busy counter MAX_AMOUNT=22 unless stated)
REQ-031 Single job: reset, then i_request in cycle 0 -> o_pending=1 in c1; o_start only in c2; i_busy in c3..c23; o_done in c25.
REQ-032 Back-to-back jobs: i_request in c0 and c1 -> first o_start in c2; second o_start in c26.
REQ-033 Overflow: i_request in c0..c5 -> o_pending 1,2,2,3,4 in c1..c5; 4 in c6; o_overflow=1 from c6.
REQ-034 Zero-length job with downstream MAX_AMOUNT=1: i_request in c0 -> o_start in c2; i_busy never high; o_done in c4.
REQ-035 Reset mid-job: i_reset_n low in c10 of the single-job case -> o_pending=0 and state IDLE in c11; a request in c12 gives no o_start until the cycle after i_busy falls (c24 -> o_start in c25).
REQ-036 Random test: random i_request with the downstream counter attached, checking REQ-022 and that starts + drops + pending always equals requests.
